uart_fifo_top: RTL

Parametrised Wishbone UART peripheral: 8N1 transmitter and receiver with independent synchronous FIFOs, a programmable baud divisor, sticky error flags and a maskable interrupt. It sits on the OR1200 data bus as a slave beside the other peripherals, replacing the single-byte lab UART. The DATA and STATUS bit positions stay software-compatible with that UART.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/wishbone_if.sv | 27 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_fifo_top.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state types for the Wishbone UART peripheral.
package uart_pkg;

    // Register offsets, selected by adr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    // STATUS bit positions (kept compatible with the old lab UART)
    localparam int ST_RX_AVAIL  = 16;
    localparam int ST_RX_OVR    = 17;
    localparam int ST_FRAME_ERR = 18;
    localparam int ST_TX_OVF    = 19;
    localparam int ST_TX_FULL   = 20;
    localparam int ST_TX_EMPTY  = 21;
    localparam int ST_TX_IDLE   = 22;

    // CTRL bit positions above the divisor field
    localparam int CT_RX_IE  = 16;
    localparam int CT_TX_IE  = 17;
    localparam int CT_ERR_IE = 18;

    // Smallest usable divisor; smaller programmed values are clamped to it
    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone slave bus bundle. dat_o carries write data from the master,
// dat_i carries read data back to it.
interface wishbone (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_i, ack, err, rty,
        output adr, dat_o, sel, we, stb, cyc
    );

    modport slave (
        input  clk, rst, adr, dat_o, sel, we, stb, cyc,
        output dat_i, ack, err, rty
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a combinational head. Push-when-full is dropped
// unless a pop happens in the same cycle; pop-when-empty is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end
endmodule

// File: rtl/uart_fifo_top.sv
// Wishbone UART: 8N1 TX/RX with FIFOs, programmable divisor, sticky errors
// and a maskable level interrupt.
module uart_fifo_top
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 217
) (
    input  logic    clk,
    input  logic    rst_n,
    wishbone.slave  wb,
    output logic    int_o,
    input  logic    srx_pad_i,
    output logic    stx_pad_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic             ack_r, int_r, stx_r;
    logic             acc_s, wr_s, rd_s;
    logic [1:0]       reg_sel_s;
    logic [DIV_W-1:0] div_r, div_eff_s;
    logic             rx_ie_r, tx_ie_r, err_ie_r;
    logic             rx_ovr_r, ferr_r, tx_ovf_r;
    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_drop_s;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_drop_s;
    logic             st_clr_s, ctrl_wr_s, tx_idle_s, rx_ferr_s;
    logic [7:0]       tx_head_s, rx_head_s;
    logic [AW:0]      tx_count_s, rx_count_s;
    logic [31:0]      rd_data_s, status_s;
    tx_state_t        tx_st_r;
    rx_state_t        rx_st_r;
    logic [DIV_W-1:0] tx_cnt_r, rx_cnt_r;
    logic [2:0]       tx_idx_r, rx_idx_r;
    logic [7:0]       tx_sh_r, rx_sh_r;
    logic [2:0]       sync_r;
    logic             rx_bit_s, rx_fall_s;
    logic             unused_ok_s;

    // Bus decode: side effects fire only in the ack cycle
    assign reg_sel_s = wb.adr[3:2];
    assign acc_s     = ack_r & wb.stb & wb.cyc;
    assign wr_s      = acc_s & wb.we;
    assign rd_s      = acc_s & ~wb.we;
    assign tx_push_s = wr_s & (reg_sel_s == REG_DATA) & wb.sel[3];
    assign rx_pop_s  = rd_s & (reg_sel_s == REG_DATA);
    assign st_clr_s  = wr_s & (reg_sel_s == REG_STATUS);
    assign ctrl_wr_s = wr_s & (reg_sel_s == REG_CTRL);
    assign tx_drop_s = tx_push_s & tx_full_s & ~tx_pop_s;
    assign rx_drop_s = rx_push_s & rx_full_s & ~rx_pop_s;
    assign div_eff_s = (div_r < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_r;
    assign tx_idle_s = tx_empty_s & (tx_st_r == TX_IDLE);
    assign tx_pop_s  = ~tx_empty_s & ((tx_st_r == TX_IDLE) |
                       ((tx_st_r == TX_STOP) & (tx_cnt_r == CNT_ZERO)));
    assign rx_bit_s  = sync_r[1];
    assign rx_fall_s = sync_r[2] & ~sync_r[1];
    assign rx_push_s = (rx_st_r == RX_STOP) & (rx_cnt_r == CNT_ZERO) & rx_bit_s;
    assign rx_ferr_s = (rx_st_r == RX_STOP) & (rx_cnt_r == CNT_ZERO) & ~rx_bit_s;

    assign wb.ack     = ack_r;
    assign wb.err     = 1'b0;
    assign wb.rty     = 1'b0;
    assign wb.dat_i   = rd_data_s;
    assign int_o      = int_r;
    assign stx_pad_o  = stx_r;
    assign unused_ok_s = ^{wb.clk, wb.rst, wb.adr[31:4], wb.adr[1:0], wb.sel[2:0]};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push_s), .pop(tx_pop_s),
        .wr_data(wb.dat_o[31:24]), .rd_data(tx_head_s),
        .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_s), .pop(rx_pop_s),
        .wr_data(rx_sh_r), .rd_data(rx_head_s),
        .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    // One-wait-state acknowledge
    always_ff @(posedge clk) begin
        if (!rst_n) ack_r <= 1'b0;
        else        ack_r <= wb.stb & wb.cyc & ~ack_r;
    end

    // CTRL register and sticky error flags (a new error wins over a clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r    <= DIV_W'(DEFAULT_DIV);
            rx_ie_r  <= 1'b0;
            tx_ie_r  <= 1'b0;
            err_ie_r <= 1'b0;
            rx_ovr_r <= 1'b0;
            ferr_r   <= 1'b0;
            tx_ovf_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                div_r    <= wb.dat_o[DIV_W-1:0];
                rx_ie_r  <= wb.dat_o[CT_RX_IE];
                tx_ie_r  <= wb.dat_o[CT_TX_IE];
                err_ie_r <= wb.dat_o[CT_ERR_IE];
            end
            rx_ovr_r <= rx_drop_s | (rx_ovr_r & ~(st_clr_s & wb.dat_o[ST_RX_OVR]));
            ferr_r   <= rx_ferr_s | (ferr_r & ~(st_clr_s & wb.dat_o[ST_FRAME_ERR]));
            tx_ovf_r <= tx_drop_s | (tx_ovf_r & ~(st_clr_s & wb.dat_o[ST_TX_OVF]));
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (!rst_n) int_r <= 1'b0;
        else        int_r <= (rx_ie_r & ~rx_empty_s) | (tx_ie_r & tx_empty_s) |
                             (err_ie_r & (rx_ovr_r | ferr_r | tx_ovf_r));
    end

    // Read-data mux, only driven during the ack cycle
    always_comb begin
        status_s = 32'h0000_0000;
        status_s[ST_RX_AVAIL]  = ~rx_empty_s;
        status_s[ST_RX_OVR]    = rx_ovr_r;
        status_s[ST_FRAME_ERR] = ferr_r;
        status_s[ST_TX_OVF]    = tx_ovf_r;
        status_s[ST_TX_FULL]   = tx_full_s;
        status_s[ST_TX_EMPTY]  = tx_empty_s;
        status_s[ST_TX_IDLE]   = tx_idle_s;
        rd_data_s = 32'h0000_0000;
        if (ack_r) begin
            case (reg_sel_s)
                REG_DATA:   rd_data_s = rx_empty_s ? 32'h0000_0000 : {rx_head_s, 24'h00_0000};
                REG_STATUS: rd_data_s = status_s;
                REG_CTRL:   rd_data_s = {13'h0000, err_ie_r, tx_ie_r, rx_ie_r, 16'(div_r)};
                REG_LEVEL:  rd_data_s = {8'(rx_count_s), 8'(tx_count_s), 16'h0000};
                default:    rd_data_s = 32'h0000_0000;
            endcase
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Two-flop synchronizer plus one history bit for start-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) sync_r <= 3'b111;
        else        sync_r <= {sync_r[1:0], srx_pad_i};
    end

    // Transmit FSM: start, 8 data bits LSB first, stop; chains frames without gaps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_st_r  <= TX_IDLE;
            tx_cnt_r <= CNT_ZERO;
            tx_idx_r <= 3'd0;
            tx_sh_r  <= 8'h00;
            stx_r    <= 1'b1;
        end else begin
            case (tx_st_r)
                TX_IDLE, TX_STOP: begin
                    if (tx_st_r == TX_STOP && tx_cnt_r != CNT_ZERO) begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end else if (tx_pop_s) begin
                        tx_sh_r  <= tx_head_s;
                        tx_cnt_r <= div_eff_s - CNT_ONE;
                        stx_r    <= 1'b0;
                        tx_st_r  <= TX_START;
                    end else begin
                        stx_r    <= 1'b1;
                        tx_st_r  <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == CNT_ZERO) begin
                        tx_cnt_r <= div_eff_s - CNT_ONE;
                        tx_idx_r <= 3'd0;
                        stx_r    <= tx_sh_r[0];
                        tx_st_r  <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == CNT_ZERO) begin
                        tx_cnt_r <= div_eff_s - CNT_ONE;
                        if (tx_idx_r == 3'd7) begin
                            stx_r   <= 1'b1;
                            tx_st_r <= TX_STOP;
                        end else begin
                            tx_idx_r <= tx_idx_r + 3'd1;
                            tx_sh_r  <= {1'b0, tx_sh_r[7:1]};
                            stx_r    <= tx_sh_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    tx_st_r <= TX_IDLE;
                    stx_r   <= 1'b1;
                end
            endcase
        end
    end

    // Receive FSM: mid-bit sampling timed from the synchronized falling edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st_r  <= RX_IDLE;
            rx_cnt_r <= CNT_ZERO;
            rx_idx_r <= 3'd0;
            rx_sh_r  <= 8'h00;
        end else begin
            case (rx_st_r)
                RX_IDLE: begin
                    if (rx_fall_s) begin
                        rx_cnt_r <= (div_eff_s >> 1) - CNT_ONE;
                        rx_st_r  <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r != CNT_ZERO) begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end else if (rx_bit_s) begin
                        rx_st_r  <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= div_eff_s - CNT_ONE;
                        rx_idx_r <= 3'd0;
                        rx_st_r  <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_ZERO) begin
                        rx_cnt_r <= div_eff_s - CNT_ONE;
                        rx_sh_r  <= {rx_bit_s, rx_sh_r[7:1]};
                        rx_idx_r <= rx_idx_r + 3'd1;
                        if (rx_idx_r == 3'd7) rx_st_r <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_ZERO) rx_st_r  <= RX_IDLE;
                    else                      rx_cnt_r <= rx_cnt_r - CNT_ONE;
                end
                default: rx_st_r <= RX_IDLE;
            endcase
        end
    end
endmodule
